uart_tx_frame: RTL
==================

// Module: uart_tx_frame
// PURPOSE
//   UART transmit framer/serializer, the TX-side counterpart of the UART_Rx path.
//   Accepts one parallel byte plus frame config via a valid/busy handshake.
//   Drives TX_OUT as: start(0), DATA_WIDTH bits LSB-first, optional parity, stop(1).
//   Each bit lasts Prescale CLK cycles; Prescale is shared with the RX side.
// PARAMETERS
//   DATA_WIDTH      8   payload bits per frame
//   PRESCALE_WIDTH  8   width of Prescale and internal bit-time counter
//   PRESCALE_MIN    4   minimum bit time; smaller Prescale values are clamped to this
// PORTS
//   CLK         in   1               system clock, all logic on posedge
//   RST         in   1               asynchronous, active-high reset
//   P_DATA      in   DATA_WIDTH      byte to send, captured on accept
//   Data_Valid  in   1               request; accepted only when Busy==0
//   PAR_EN      in   1               1: insert parity bit, captured on accept
//   PAR_TYP     in   1               0: even, 1: odd, captured on accept
//   Prescale    in   PRESCALE_WIDTH  CLK cycles per bit, captured on accept
//   TX_OUT      out  1               serial line, idles high
//   Busy        out  1               high from first start-bit cycle to last stop-bit cycle
// BEHAVIOUR
//   Reset (async, any time incl. mid-frame): TX_OUT=1, Busy=0, FSM=IDLE, counters=0.
//   Reset takes effect immediately; the partial frame is abandoned, no stop bit sent.
//   FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE: TX_OUT=1, Busy=0. Data_Valid=1 at edge N -> capture P_DATA, PAR_EN,
//     PAR_TYP, eff_pre=max(Prescale,PRESCALE_MIN); enter START at N.
//     TX_OUT=0 and Busy=1 visible from cycle N+1 (1-cycle latency).
//   Bit timer: counts 0..eff_pre-1; the state/bit index advances on terminal count.
//   START: TX_OUT=0 for eff_pre cycles -> DATA, bit index 0.
//   DATA: TX_OUT=shift_reg[0]; on terminal count shift right, idx++;
//     after idx DATA_WIDTH-1 -> PARITY if PAR_EN else STOP.
//   PARITY: TX_OUT = ^data_latched ^ PAR_TYP, for eff_pre cycles -> STOP.
//   STOP: TX_OUT=1 for eff_pre cycles -> IDLE; Busy falls in the same cycle
//     TX_OUT would begin the next bit (i.e. after eff_pre stop cycles).
//   Frame length exactly (2+DATA_WIDTH+PAR_EN)*eff_pre cycles of Busy=1.
//   Minimum one IDLE cycle between frames; back-to-back Data_Valid held high
//     starts the next frame on the first IDLE edge (gap = 1 cycle of TX_OUT=1).
//   Data_Valid while Busy=1: ignored, not queued; no effect on the frame in flight.
//   P_DATA/PAR_EN/PAR_TYP/Prescale changes mid-frame: ignored (latched values used).
//   Outputs are registered (glitch-free TX_OUT); no combinational in->out path.
// STRUCTURE
//   Shared package uart_pkg: FSM state encoding localparams, PAR_EVEN/PAR_ODD,
//     PRESCALE_MIN default, so RX and TX agree on frame format.
//   One sub-module: uart_tx_bit_timer (load eff_pre, count, emit bit_done pulse).
//   FSM, shift register, and parity calculation stay in uart_tx_frame.
// TESTING
//   Prescale=8, PAR_EN=0, P_DATA=0xA5 -> TX_OUT 0,1,0,1,0,0,1,0,1,1 each 8 cycles; Busy high 80 cycles.
//   Prescale=8, PAR_EN=1, PAR_TYP=0, 0xA5 -> parity bit 0; PAR_TYP=1 -> parity bit 1; Busy 88 cycles.
//   Mid-frame Data_Valid=1 with P_DATA=0x3C and Prescale=16 -> current 0xA5 frame unchanged, 0x3C never sent.
//   Data_Valid held high, 0x01 then 0x80 -> two frames separated by exactly 1 idle cycle of TX_OUT=1.
//   RST pulsed during DATA bit 3 -> TX_OUT=1, Busy=0 same cycle; next request sends a clean full frame.
//   Prescale=2 -> each bit held 4 cycles (clamp); Prescale=255 -> each bit held 255 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Frame-format constants shared by the UART TX and RX paths so both sides agree
// on state encoding, parity sense and the minimum bit time.
package uart_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned PRESCALE_MIN_DEF = 4;

    // Parity bit from the XOR-reduced payload and the configured parity sense.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return data_xor ^ (par_typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-time counter for the UART transmitter: loaded with the effective prescale on
// frame accept, counts 0..eff_pre-1 while running and flags the last cycle of a bit.
module uart_tx_bit_timer #(
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      i_load,
    input  logic                      i_run,
    input  logic [PRESCALE_WIDTH-1:0] i_eff_pre,
    output logic                      o_bit_done_c
);

    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [PRESCALE_WIDTH-1:0] r_limit;
    logic                      w_terminal;

    assign w_terminal   = (r_cnt == r_limit);
    assign o_bit_done_c = i_run && w_terminal;

    // Terminal value is stored as eff_pre-1 so the compare is a plain equality.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt   <= '0;
            r_limit <= '0;
        end else if (i_load) begin
            r_cnt   <= '0;
            r_limit <= i_eff_pre - PRESCALE_WIDTH'(1);
        end else if (i_run) begin
            if (w_terminal) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, stop bit,
// each held for max(Prescale, PRESCALE_MIN) clocks; TX_OUT and Busy are registered.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 8,
    parameter int unsigned PRESCALE_MIN   = PRESCALE_MIN_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] PRE_MIN = PRESCALE_WIDTH'(PRESCALE_MIN);

    logic [STATE_W-1:0]        r_state;
    logic [STATE_W-1:0]        w_state_next;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic [DATA_WIDTH-1:0]     w_shift_next;
    logic [IDX_W-1:0]          r_bit_idx;
    logic                      r_par_en;
    logic                      r_par_bit;
    logic                      r_tx_out;
    logic                      r_busy;
    logic                      w_tx_next;
    logic                      w_busy_next;
    logic                      w_accept;
    logic                      w_shift_en;
    logic                      w_bit_done;
    logic [PRESCALE_WIDTH-1:0] w_eff_pre;

    assign w_eff_pre    = (Prescale < PRE_MIN) ? PRE_MIN : Prescale;
    assign w_shift_next = r_shift >> 1;
    assign TX_OUT       = r_tx_out;
    assign Busy         = r_busy;

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_bit_timer (
        .CLK         (CLK),
        .RST         (RST),
        .i_load      (w_accept),
        .i_run       (r_state != ST_IDLE),
        .i_eff_pre   (w_eff_pre),
        .o_bit_done_c(w_bit_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus next line/busy values; the line value for the coming bit is
    // registered on the same edge the state advances, so TX_OUT never glitches.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx_out;
        w_busy_next  = r_busy;
        w_accept     = 1'b0;
        w_shift_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
                if (Data_Valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_START;
                    w_tx_next    = 1'b0;
                    w_busy_next  = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_next = ST_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == LAST_IDX) begin
                        if (r_par_en) begin
                            w_state_next = ST_PARITY;
                            w_tx_next    = r_par_bit;
                        end else begin
                            w_state_next = ST_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_tx_next = w_shift_next[0];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_next = ST_STOP;
                    w_tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_state_next = ST_IDLE;
                    w_tx_next    = 1'b1;
                    w_busy_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx_out <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_tx_out <= w_tx_next;
            r_busy   <= w_busy_next;
        end
    end

    // Frame configuration is latched on accept; later input changes are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= P_DATA;
            r_bit_idx <= '0;
            r_par_en  <= PAR_EN;
            r_par_bit <= parity_bit(^P_DATA, PAR_TYP);
        end else if (w_shift_en) begin
            r_shift   <= w_shift_next;
            r_bit_idx <= r_bit_idx + IDX_W'(1);
        end
    end

endmodule
